// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store responder between the datapath and a word-wide valid/ready memory bus
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        load,
  input  logic [1:0]        store,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Counter value on the last BUSY cycle allowed before the bus is declared dead
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;

  logic        ld_valid;
  logic        op_valid;
  logic        op_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        aligned;
  logic [3:0]  op_be;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  // Decode the requested operation; a load takes priority over a simultaneous store
  always_comb begin
    ld_valid    = (load >= 3'd1) && (load <= 3'd5);
    op_valid    = ld_valid || (store != 2'b00);
    op_store    = !ld_valid && (store != 2'b00);
    op_size     = SZ_W;
    op_unsigned = 1'b0;
    if (ld_valid) begin
      case (load)
        3'd1:    op_size = SZ_B;
        3'd2:    op_size = SZ_H;
        3'd4: begin
          op_size     = SZ_B;
          op_unsigned = 1'b1;
        end
        3'd5: begin
          op_size     = SZ_H;
          op_unsigned = 1'b1;
        end
        default: op_size = SZ_W;
      endcase
    end else begin
      case (store)
        2'b01:   op_size = SZ_B;
        2'b10:   op_size = SZ_H;
        default: op_size = SZ_W;
      endcase
    end
    case (op_size)
      SZ_H:    aligned = !addr[0];
      SZ_W:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (op_size)
      SZ_B:    op_be = 4'b0001 << addr[1:0];
      SZ_H:    op_be = 4'b0011 << addr[1:0];
      default: op_be = 4'b1111;
    endcase
  end

  // Bring the addressed lane down to bit 0 and extend according to the latched load type
  always_comb begin
    rd_shift = mem_rdata >> {lat_off, 3'b000};
    case (lat_size)
      SZ_B:    rd_ext = lat_unsigned ? {24'h0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    rd_ext = lat_unsigned ? {16'h0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Hold the core from the accepting IDLE cycle until the transfer has finished
  assign stall = (state == S_BUSY) || ((state == S_IDLE) && op_valid && aligned);

  // Transaction sequencer: accept in IDLE, run the bus in BUSY, release the core in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      rdata        <= 32'h0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0;
      mem_be       <= 4'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      lat_size     <= SZ_W;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (aligned) begin
              mem_addr     <= addr[ADDR_W+1:2];
              mem_we       <= op_store;
              mem_be       <= op_be;
              mem_wdata    <= wdata << {addr[1:0], 3'b000};
              lat_size     <= op_size;
              lat_unsigned <= op_unsigned;
              lat_off      <= addr[1:0];
              mem_req      <= 1'b1;
              cnt          <= 8'd0;
              state        <= S_BUSY;
            end else begin
              misalign_err <= 1'b1;
              rdata        <= 32'h0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            if (!mem_we) rdata <= rd_ext;
            mem_req <= 1'b0;
            cnt     <= 8'd0;
            state   <= S_DONE;
          end else if (cnt == TO_LAST) begin
            if (!mem_we) rdata <= 32'h0;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            cnt     <= 8'd0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  load = 3'd0;
  logic [1:0]  store = 2'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  lsu_mem_ctrl #(.ADDR_W(30), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .load(load), .store(store),
    .rdata(rdata), .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
  } bus_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        berr;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  int    exp_stall[$];
  int    exp_mis[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge and checks against the scoreboard queues
  bus_t  cap;
  bus_t  eb;
  done_t ed;
  logic  prev_req = 1'b0;
  int    run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      run = 0;
    end else begin
      if (mem_req && !prev_req) begin
        chk("req_expected", 32'(exp_bus.size() > 0), 32'd1);
        if (exp_bus.size() > 0) begin
          eb = exp_bus.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(eb.a));
          chk("mem_be", 32'(mem_be), 32'(eb.be));
          chk("mem_we", 32'(mem_we), 32'(eb.we));
          chk("mem_wdata", mem_wdata, eb.wd);
        end
        cap = {mem_addr, mem_be, mem_we, mem_wdata};
      end else if (mem_req && prev_req) begin
        chk("stable_addr", 32'(mem_addr), 32'(cap.a));
        chk("stable_be", 32'(mem_be), 32'(cap.be));
        chk("stable_we", 32'(mem_we), 32'(cap.we));
        chk("stable_wdata", mem_wdata, cap.wd);
      end
      if (!mem_req && prev_req) begin
        chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
          ed = exp_done.pop_front();
          chk("rdata", rdata, ed.rd);
          chk("bus_err", 32'(bus_err), 32'(ed.berr));
        end
        chk("stall_in_done", 32'(stall), 32'd0);
      end else if (bus_err) begin
        chk("bus_err_spurious", 32'(bus_err), 32'd0);
      end
      if (misalign_err) begin
        chk("misalign_expected", 32'(exp_mis.size() > 0), 32'd1);
        if (exp_mis.size() > 0) void'(exp_mis.pop_front());
      end
      if (stall) begin
        run++;
      end else if (run > 0) begin
        chk("stall_expected", 32'(exp_stall.size() > 0), 32'd1);
        if (exp_stall.size() > 0) chk("stall_cycles", 32'(run), 32'(exp_stall.pop_front()));
        run = 0;
      end
      prev_req = mem_req;
    end
  end

  // dly: BUSY cycle (1-based) on which mem_ready is raised; 0 = never
  task automatic op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                    input bus_t b, input done_t d);
    int k;
    exp_bus.push_back(b);
    exp_done.push_back(d);
    exp_stall.push_back(1 + ((dly == 0) ? TO : dly));
    @(posedge clk); #1;
    load = ld; store = st; addr = a; wdata = wd; mem_rdata = mrd;
    @(posedge clk); #1;
    load = 3'd0; store = 2'd0;
    k = 1;
    mem_ready = (dly == k);
    while (mem_req && k <= TO + 2) begin
      @(posedge clk); #1;
      k++;
      mem_ready = (dly == k);
    end
    mem_ready = 1'b0;
    if (mem_req) chk("op_finished", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic op_misaligned(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a);
    exp_mis.push_back(1);
    @(posedge clk); #1;
    load = ld; store = st; addr = a;
    @(posedge clk); #1;
    load = 3'd0; store = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    op(3'd0, 2'b11, 32'h10, 32'hDEADBEEF, 32'h0, 2, {30'h4, 4'b1111, 1'b1, 32'hDEADBEEF}, {32'h0, 1'b0});
    op(3'd1, 2'b00, 32'h13, 32'h0, 32'h80FF1234, 1, {30'h4, 4'b1000, 1'b0, 32'h0}, {32'hFFFFFF80, 1'b0});
    op(3'd4, 2'b00, 32'h13, 32'h0, 32'h80FF1234, 1, {30'h4, 4'b1000, 1'b0, 32'h0}, {32'h00000080, 1'b0});
    op(3'd2, 2'b00, 32'h12, 32'h0, 32'h80FF1234, 1, {30'h4, 4'b1100, 1'b0, 32'h0}, {32'hFFFF80FF, 1'b0});
    op(3'd5, 2'b00, 32'h12, 32'h0, 32'h80FF1234, 1, {30'h4, 4'b1100, 1'b0, 32'h0}, {32'h000080FF, 1'b0});
    op(3'd0, 2'b01, 32'h11, 32'hAB, 32'h0, 1, {30'h4, 4'b0010, 1'b1, 32'h0000AB00}, {32'h000080FF, 1'b0});
    op_misaligned(3'd0, 2'b10, 32'h13);
    op(3'd3, 2'b00, 32'h20, 32'h0, 32'h5555AAAA, 0, {30'h8, 4'b1111, 1'b0, 32'h0}, {32'h0, 1'b1});
    op(3'd2, 2'b11, 32'h12, 32'h11223344, 32'h80FF1234, 3, {30'h4, 4'b1100, 1'b0, 32'h33440000}, {32'hFFFF80FF, 1'b0});

    // Reset in the middle of BUSY
    exp_bus.push_back({30'h10, 4'b1111, 1'b0, 32'h0});
    @(posedge clk); #1;
    load = 3'd3; addr = 32'h40; wdata = 32'h0;
    @(posedge clk); #1;
    load = 3'd0;
    @(posedge clk); #1;
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    op(3'd3, 2'b00, 32'h0, 32'h0, 32'h12345678, 1, {30'h0, 4'b1111, 1'b0, 32'h0}, {32'h12345678, 1'b0});

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bus_q_empty", 32'(exp_bus.size()), 32'd0);
    chk("done_q_empty", 32'(exp_done.size()), 32'd0);
    chk("stall_q_empty", 32'(exp_stall.size()), 32'd0);
    chk("mis_q_empty", 32'(exp_mis.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store responder that sits between the single-cycle datapath's memory-request outputs and a word-wide data memory bus. It takes the byte address (ALU result), store data and load/store type for the current instruction and stalls the core while it runs a valid/ready transaction. It handles byte-lane alignment, write byte-enables, load sign/zero extension, misalignment detection and bus timeout.

Parameters:
ADDR_W, 30, word-address width on the memory bus (byte address bits [ADDR_W+1:2]).
TIMEOUT, 16, maximum BUSY cycles without mem_ready before a bus error is flagged (range 1 to 255).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
addr  in  32  byte address from datapath ALU result
wdata  in  32  store data from datapath (rs2)
load  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none
store  in  2  00 none, 01 SB, 10 SH, 11 SW
rdata  out  32  extended load result, registered
stall  out  1  core must hold PC/instruction while high
misalign_err  out  1  one-cycle pulse: misaligned access rejected
bus_err  out  1  one-cycle pulse: timeout expired
mem_req  out  1  bus request valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  lane-shifted write data
mem_be  out  4  byte enables (bit n = byte lane n)
mem_ready  in  1  bus accepts or completes transfer this cycle
mem_rdata  in  32  read word, valid when mem_ready is high on a read

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, bus_err=0, timeout counter=0. stall=0 because it decodes from state IDLE. Reset during BUSY drops mem_req immediately; no retry.
- Op valid = load in {001..101} or store≠00. If both are set, the load wins and the store is ignored.
- Alignment: H ops need addr[0]=0. W ops need addr[1:0]=00. B ops are always aligned.
- States: IDLE, BUSY, DONE.
- IDLE, valid and aligned op:
  - stall=1 combinationally in the same cycle.
  - Register mem_addr=addr[ADDR_W+1:2] and mem_we=(store op), and latch the op type and addr[1:0].
  - mem_be: B=0001<<addr[1:0]; H=0011<<addr[1:0]; W=1111.
  - mem_wdata=wdata<<(8*addr[1:0]); for SW it is wdata unshifted.
  - Next state is BUSY.
- IDLE, valid but misaligned op: stall=0, no bus request, misalign_err pulses high the next cycle, rdata←0, stay in IDLE.
- BUSY:
  - mem_req=1, stall=1, counter increments each cycle.
  - When mem_ready=1: for a read, rdata←extend(mem_rdata>>(8*addr[1:0])); the counter clears and the next state is DONE.
  - Extension: LB sign-extends bit 7, LBU zero-extends bit 7, LH sign-extends bit 15, LHU zero-extends bit 15, LW takes the word unchanged. For a write, rdata is unchanged.
  - Timeout: if the counter reaches TIMEOUT with mem_ready=0, bus_err pulses one cycle, rdata←0 for a read, mem_req drops and the next state is DONE.
- DONE: stall=0, mem_req=0, and rdata holds the result. The core advances at this edge. The next state is always IDLE, so inputs seen in DONE are never re-issued.
- Address, data and byte enables stay stable for the whole of BUSY.
- Latency: minimum 3 cycles per access (IDLE, BUSY with ready, DONE). stall is high for 1 + N BUSY cycles.
- mem_ready outside BUSY is ignored.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, mem_ready high on the 2nd BUSY cycle → mem_addr=0x4, mem_be=1111, mem_we=1, mem_wdata=0xDEADBEEF; stall high 3 cycles, low in DONE.
- LB addr=0x13, mem_rdata=0x80FF1234, ready on the 1st BUSY cycle → rdata=0xFFFFFF80 in DONE. Repeat with LBU → 0x00000080.
- LH addr=0x12, mem_rdata=0x80FF1234 → rdata=0xFFFF80FF; LHU → 0x000080FF; mem_be=1100, mem_we=0.
- SB addr=0x11 wdata=0x000000AB → mem_be=0010, mem_wdata=0x0000AB00. SH addr=0x13 → no mem_req, stall never high, misalign_err 1-cycle pulse.
- LW with mem_ready held low, TIMEOUT=4 → bus_err pulses after 4 BUSY cycles, rdata=0, state goes DONE then IDLE.
- rst pulsed low mid-BUSY → mem_req, stall and rdata go 0 asynchronously. After release, an LW at addr 0x0 completes normally.
